// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared constants and index/reduction helpers for the NTT output path
package ntt_pkg;

  localparam int NTT_W       = 32;
  localparam int NTT_MODULUS = 7681;

  // Reverses the low log_n bits of idx; bits above log_n come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int log_n);
    logic [31:0] r;
    logic [31:0] x;
    r = '0;
    x = idx;
    for (int i = 0; i < 32; i++) begin
      if (i < log_n) begin
        r = {r[30:0], x[0]};
        x = x >> 1;
      end
    end
    return r;
  endfunction

  function automatic logic [NTT_W-1:0] cond_sub(input logic [NTT_W-1:0] x,
                                                input logic [NTT_W-1:0] m);
    return (x >= m) ? x - m : x;
  endfunction

endpackage

// File: rtl/ntt_pingpong_ram.sv
// rtl/ntt_pingpong_ram.sv - two-bank N x W storage, synchronous write, combinational read
module ntt_pingpong_ram #(
  parameter int W = 32,
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic                 wr_bank,
  input  logic [$clog2(N)-1:0] wr_addr,
  input  logic [W-1:0]         wr_data,
  input  logic                 rd_bank,
  input  logic [$clog2(N)-1:0] rd_addr,
  output logic [W-1:0]         rd_data
);

  logic [W-1:0] mem [0:1][0:N-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_bank][wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_bank][rd_addr];

endmodule

// File: rtl/ntt_bitrev_collector.sv
// rtl/ntt_bitrev_collector.sv - reorders bit-reversed NTT results into natural order, double-buffered
// Optional write-path modular reduction enabled by defining NTT_REDUCE_EN.
module ntt_bitrev_collector
  import ntt_pkg::*;
#(
  parameter int W       = NTT_W,
  parameter int N       = 8,
  parameter int MODULUS = NTT_MODULUS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic [15:0]  frame_count
);

  localparam int LOG_N = $clog2(N);

  logic [1:0]       bank_full;
  logic             wbank;
  logic             rbank;
  logic [LOG_N-1:0] wcnt;
  logic [LOG_N-1:0] rcnt;
  logic [LOG_N-1:0] waddr;
  logic [W-1:0]     wr_data;
  logic [W-1:0]     rd_data;
  logic             accept;
  logic             load;

  // Unsupported N/MODULUS settings elaborate this empty marker block.
  if (N < 2 || (N & (N - 1)) != 0 || MODULUS < 2) begin : g_bad_config
  end

  // Registered flag only: a bank freed this edge is writable from the next cycle.
  assign in_ready = !bank_full[wbank];
  assign accept   = in_valid && in_ready;
  assign load     = bank_full[rbank] && (!out_valid || out_ready);
  assign waddr    = LOG_N'(bitrev(32'(wcnt), LOG_N));

`ifdef NTT_REDUCE_EN
  assign wr_data = W'(cond_sub(NTT_W'(in_data), NTT_W'(MODULUS)));
`else
  assign wr_data = in_data;
`endif

  ntt_pingpong_ram #(
    .W(W),
    .N(N)
  ) u_ram (
    .clk     (clk),
    .we      (accept),
    .wr_bank (wbank),
    .wr_addr (waddr),
    .wr_data (wr_data),
    .rd_bank (rbank),
    .rd_addr (rcnt),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_full   <= '0;
      wbank       <= 1'b0;
      rbank       <= 1'b0;
      wcnt        <= '0;
      rcnt        <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_data    <= '0;
      frame_count <= '0;
    end else begin
      if (accept) begin
        if (wcnt == LOG_N'(N - 1)) begin
          bank_full[wbank] <= 1'b1;
          wbank            <= ~wbank;
          wcnt             <= '0;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
      end

      if (load) begin
        out_data  <= rd_data;
        out_last  <= (rcnt == LOG_N'(N - 1));
        out_valid <= 1'b1;
        if (rcnt == LOG_N'(N - 1)) begin
          bank_full[rbank] <= 1'b0;
          rbank            <= ~rbank;
          rcnt             <= '0;
          frame_count      <= frame_count + 16'd1;
        end else begin
          rcnt <= rcnt + 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ntt_bitrev_collector.sv
// tb/tb_ntt_bitrev_collector.sv - randomized self-checking bench against a frame-level reorder model
module tb_ntt_bitrev_collector;

  localparam int W     = 32;
  localparam int N     = 8;
  localparam int LOG_N = 3;
  localparam int MOD   = 7681;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_last;
  logic [15:0]  frame_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_n = 0;

  logic [W-1:0] cur_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  bit           exp_last_q[$];
  bit           got_last_q[$];
  int           got_cyc_q[$];

  ntt_bitrev_collector dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1);
  end

  function automatic int rev(int j);
    int r = 0;
    int x = j;
    for (int b = 0; b < LOG_N; b++) begin
      r = r * 2 + x % 2;
      x = x / 2;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] stored_value(logic [W-1:0] v);
`ifdef NTT_REDUCE_EN
    return (v >= MOD) ? v - MOD : v;
`else
    return v;
`endif
  endfunction

  // Arrival k carries natural index rev(k), so natural slot j holds arrival rev(j).
  task automatic model_accept(logic [W-1:0] v);
    cur_q.push_back(stored_value(v));
    acc_n++;
    if (cur_q.size() == N) begin
      for (int j = 0; j < N; j++) begin
        exp_q.push_back(cur_q[rev(j)]);
        exp_last_q.push_back(j == N - 1);
      end
      cur_q.delete();
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (in_valid && in_ready) model_accept(in_data);
    if (out_valid && out_ready) begin
      got_q.push_back(out_data);
      got_last_q.push_back(out_last);
      got_cyc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cur_q.delete();
    exp_q.delete();
    exp_last_q.delete();
    got_q.delete();
    got_last_q.delete();
    got_cyc_q.delete();
    acc_n = 0;
  endtask

  task automatic run_idle(int n);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (got_q.size() >= exp_q.size() && !out_valid) break;
      step();
    end
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b want=0", out_last); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%0d want=0", out_data); end
    total++; if (frame_count !== 16'd0) begin bad++; $display("FAIL reset_frame_count got=%0d want=0", frame_count); end
  endtask

  task automatic test_order();
    int want[8];
    want = '{100, 104, 102, 106, 101, 105, 103, 107};
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_data = 100 + i;
      step();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL order_valid_at_last_accept got=%b want=0", out_valid); end
    in_valid = 1'b0;
    step();
    total++; if (out_valid !== 1'b1 || out_data !== 100) begin bad++; $display("FAIL order_first_load got=%b/%0d want=1/100", out_valid, out_data); end
    run_idle(30);
    total++; if (got_q.size() !== N) begin bad++; $display("FAIL order_count got=%0d want=%0d", got_q.size(), N); end
    for (int i = 0; i < N && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== want[i] || got_last_q[i] !== (i == N - 1)) begin
        bad++; $display("FAIL order_word%0d got=%0d/%b want=%0d/%b", i, got_q[i], got_last_q[i], want[i], i == N - 1);
      end
    end
    total++; if (frame_count !== 16'd1) begin bad++; $display("FAIL order_frame_count got=%0d want=1", frame_count); end
  endtask

  task automatic test_back_to_back();
    int drops = 0;
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4 * N; i++) begin
      in_valid = 1'b1;
      in_data = $urandom_range(0, 2 * MOD - 1);
      step();
      if (in_ready !== 1'b1) drops++;
    end
    run_idle(40);
    total++; if (drops !== 0) begin bad++; $display("FAIL b2b_in_ready_drops got=%0d want=0", drops); end
    total++; if (got_q.size() !== exp_q.size() || got_q.size() !== 4 * N) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", got_q.size(), 4 * N); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i] || got_last_q[i] !== exp_last_q[i]) begin
        bad++; $display("FAIL b2b_word%0d got=%0d/%b want=%0d/%b", i, got_q[i], got_last_q[i], exp_q[i], exp_last_q[i]);
      end
    end
    if (got_cyc_q.size() == 4 * N) begin
      total++;
      if (got_cyc_q[4 * N - 1] - got_cyc_q[0] !== 4 * N - 1) begin
        bad++; $display("FAIL b2b_contiguous got_span=%0d want=%0d", got_cyc_q[4 * N - 1] - got_cyc_q[0], 4 * N - 1);
      end
    end
    total++; if (frame_count !== 16'd4) begin bad++; $display("FAIL b2b_frame_count got=%0d want=4", frame_count); end
  endtask

  task automatic test_backpressure();
    int wait_n = 0;
    apply_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 2 * N + 1; i++) begin
      in_valid = 1'b1;
      in_data = $urandom_range(0, 2 * MOD - 1);
      step();
      if (i == 2 * N - 1) begin
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready_full got=%b want=0", in_ready); end
      end
    end
    total++; if (acc_n !== 2 * N) begin bad++; $display("FAIL bp_accepted got=%0d want=%0d", acc_n, 2 * N); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      step();
      if (in_ready === 1'b1) begin wait_n = j; break; end
    end
    total++; if (wait_n !== N - 1) begin bad++; $display("FAIL bp_ready_return got=%0d want=%0d", wait_n, N - 1); end
    run_idle(60);
    total++; if (got_q.size() !== 2 * N) begin bad++; $display("FAIL bp_count got=%0d want=%0d", got_q.size(), 2 * N); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i] || got_last_q[i] !== exp_last_q[i]) begin
        bad++; $display("FAIL bp_word%0d got=%0d want=%0d", i, got_q[i], exp_q[i]);
      end
    end
    total++; if (frame_count !== 16'd2) begin bad++; $display("FAIL bp_frame_count got=%0d want=2", frame_count); end
  endtask

  task automatic test_random_stalls();
    int hold_bad = 0;
    logic pv, pr, pl;
    logic [W-1:0] pd;
    apply_reset();
    for (int c = 0; c < 3000 && (acc_n < 10 * N || got_q.size() < exp_q.size() || out_valid); c++) begin
      in_valid = (acc_n < 10 * N) && ($urandom_range(0, 3) != 0);
      in_data = $urandom_range(0, 2 * MOD - 1);
      out_ready = $urandom_range(0, 1);
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
      step();
      if (pv && !pr && (out_valid !== 1'b1 || out_data !== pd || out_last !== pl)) hold_bad++;
    end
    total++; if (hold_bad !== 0) begin bad++; $display("FAIL stall_hold violations=%0d want=0", hold_bad); end
    total++; if (got_q.size() !== 10 * N || exp_q.size() !== 10 * N) begin bad++; $display("FAIL stall_count got=%0d want=%0d", got_q.size(), 10 * N); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i] || got_last_q[i] !== exp_last_q[i]) begin
        bad++; $display("FAIL stall_word%0d got=%0d/%b want=%0d/%b", i, got_q[i], got_last_q[i], exp_q[i], exp_last_q[i]);
      end
    end
    total++; if (frame_count !== 16'd10) begin bad++; $display("FAIL stall_frame_count got=%0d want=10", frame_count); end
  endtask

  task automatic test_reduction();
    logic [W-1:0] want0;
`ifdef NTT_REDUCE_EN
    want0 = 9;
`else
    want0 = 7690;
`endif
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_data = (i == 0) ? 7690 : (i == 1) ? 7680 : $urandom_range(0, MOD - 1);
      step();
    end
    run_idle(30);
    total++; if (got_q.size() !== N) begin bad++; $display("FAIL red_count got=%0d want=%0d", got_q.size(), N); end
    if (got_q.size() == N) begin
      total++; if (got_q[0] !== want0) begin bad++; $display("FAIL red_7690 got=%0d want=%0d", got_q[0], want0); end
      total++; if (got_q[4] !== 7680) begin bad++; $display("FAIL red_7680 got=%0d want=7680", got_q[4]); end
      for (int i = 0; i < N; i++) begin
        total++;
        if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL red_word%0d got=%0d want=%0d", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int want[8];
    want = '{0, 4, 2, 6, 1, 5, 3, 7};
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_data = $urandom_range(1000, 5000);
      step();
    end
    run_idle(30);
    total++; if (frame_count !== 16'd1) begin bad++; $display("FAIL mid_pre_frame_count got=%0d want=1", frame_count); end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data = $urandom_range(1000, 5000);
      step();
    end
    apply_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%b want=0", out_valid); end
    total++; if (frame_count !== 16'd0) begin bad++; $display("FAIL mid_frame_count got=%0d want=0", frame_count); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%b want=1", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_data = i;
      step();
    end
    run_idle(30);
    total++; if (got_q.size() !== N) begin bad++; $display("FAIL mid_count got=%0d want=%0d", got_q.size(), N); end
    for (int i = 0; i < N && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== want[i] || got_last_q[i] !== (i == N - 1)) begin
        bad++; $display("FAIL mid_word%0d got=%0d want=%0d", i, got_q[i], want[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_order();
    test_back_to_back();
    test_backpressure();
    test_random_stalls();
    test_reduction();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ntt_bitrev_collector.md
# ntt_bitrev_collector

Output-side companion to the streaming NTT core. It accepts the core's result stream, which arrives in bit-reversed index order, and re-emits each N-point frame in natural index order over a valid/ready stream. It double-buffers so one frame is written while the previous frame is read out. It sits between the NTT core's result/done pair and any downstream consumer (the INTT input, a DMA or a checker).

## Interface
- W, 32, data word width.
- N, 8, points per frame; power of two, ≥ 2; LOG_N = $clog2(N).
- MODULUS, 7681, prime modulus used by the optional reduction.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  input word present; driven from the core's done.
- in_data  in  W  input word; driven from the core's final_result.
- in_ready  out  1  collector can accept in_data this cycle.
- out_valid  out  1  out_data/out_last valid.
- out_ready  in  1  consumer accepts the word this cycle.
- out_data  out  W  natural-order output word.
- out_last  out  1  marks index N-1 of a frame.
- frame_count  out  16  number of frames fully drained; wraps at 2^16.

## Operation
- Storage: two banks of N words each. Flags bank_full[1:0]. Write state: wbank, wcnt[LOG_N-1:0]. Read state: rbank, rcnt[LOG_N-1:0].
- Accept when in_valid && in_ready, with in_ready = !bank_full[wbank]. Write the word to mem[wbank][bitrev(wcnt)], then increment wcnt.
- Accepting at wcnt == N-1: set bank_full[wbank], toggle wbank, and clear wcnt.
- Load condition: bank_full[rbank] && (!out_valid || out_ready). On load:
  - out_data <= mem[rbank][rcnt]
  - out_last <= (rcnt == N-1)
  - out_valid <= 1
  - rcnt increments
- Load at rcnt == N-1: clear bank_full[rbank], toggle rbank, clear rcnt, and increment frame_count.
- No load while out_ready is high: out_valid <= 0.
- While out_valid && !out_ready, out_data and out_last hold stable.
- bitrev reverses the LOG_N low bits. Example for N=8: 1→4, 3→6, 6→3.
- The writer sets only a bank whose flag is 0; the reader clears only a bank whose flag is 1. A set and a clear of the same bank in one cycle therefore cannot occur.
- A bank freed by the reader on edge k is visible through in_ready after edge k. This is the flag's registered value, with no bypass.
- If in_valid is low mid-frame, wcnt holds. There is no frame timeout.
- Reset (at any time, including mid-frame):
  - bank_full = 0, wbank = rbank = 0, wcnt = rcnt = 0
  - out_valid = 0, out_last = 0, out_data = 0, frame_count = 0
  - in_ready = 1 after reset.
  - Memory contents are not cleared. Partial frames are discarded.

## Timing
- If the final word of a frame is sampled at edge k, the flag is set at edge k. Output index 0 is loaded at edge k+1, so out_valid is high after k+1.
- Frame latency: last input to first output is 1 cycle. First input to first output is N cycles.
- Throughput: 1 word/cycle sustained with in_valid = out_ready = 1 continuously; in_ready never drops in that case.
- With out_ready held low, the collector absorbs 2N words. in_ready goes low after the 2N-th accept.
- No combinational path from out_ready to in_ready or from in_valid to out_valid.

## Configuration
- NTT_REDUCE_EN defined: on the write path, in_data ≥ MODULUS is stored as in_data − MODULUS, using a single conditional subtraction. Inputs must be < 2·MODULUS. Latency is unchanged.
- NTT_REDUCE_EN undefined: words are stored unmodified and MODULUS is unused.

## Structure
- Package ntt_pkg holds:
  - constants NTT_W and NTT_MODULUS
  - function bitrev(idx, LOG_N)
  - function cond_sub(x, m)
- NTT_REDUCE_EN is read only in this block.
- Sub-module ntt_pingpong_ram holds the 2×N×W array. It has synchronous write (bank, addr, data, we) and combinational read (bank, addr). The flags, counters and output register stay in ntt_bitrev_collector.

## Test plan
- Order check: N=8, out_ready=1, inputs 100..107 on consecutive cycles → out_data 100,104,102,106,101,105,103,107; out_last only on 107; out_valid rises 1 cycle after the 107 accept.
- Back-to-back: 4 frames streamed without gaps, out_ready=1 → in_ready stays 1, outputs contiguous, frame_count = 4.
- Backpressure: out_ready=0, offer 17 words → 16 accepted, in_ready=0 on the 17th. Raise out_ready → first frame drains in order; in_ready returns 1 the cycle after frame 1's last load.
- Random out_ready stalls → out_data holds while out_valid && !out_ready; no word lost or duplicated across 10 frames against the reference model.
- Reduction: with NTT_REDUCE_EN, input 7690 → output 9 and 7680 → 7680; without the macro, 7690 → 7690.
- Reset mid-frame: accept 5 words, pulse rst → out_valid=0, frame_count=0, in_ready=1. A following full frame 0..7 emerges as 0,4,2,6,1,5,3,7.
